// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron training engine: sum width,
// default training threshold, weight-row slicing and the update FSM states.
package perceptron_pkg;

   localparam int THETA_DEFAULT = 68;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      EVAL = 3'd3,
      WB   = 3'd4
   } upd_state_t;

   // Wide enough that the sum of HIST+1 full-scale weights cannot overflow.
   function automatic int y_bits(input int w_bits, input int hist);
      return w_bits + $clog2(hist + 1) + 1;
   endfunction

   // LSB position of weight i inside a packed weight row.
   function automatic int row_lsb(input int i, input int w_bits);
      return i * w_bits;
   endfunction

endpackage

// File: rtl/perceptron_dot.sv
// Combinational perceptron evaluation: signed dot product, train decision and
// saturating +/-1 row update. Zero latency, no flow control.
module perceptron_dot
   import perceptron_pkg::*;
#(
   parameter int HIST   = 28,
   parameter int W_BITS = 8,
   parameter int THETA  = THETA_DEFAULT,
   parameter int Y_BITS = y_bits(W_BITS, HIST)
) (
   input  logic [(HIST+1)*W_BITS-1:0] row,
   input  logic [HIST-1:0]            hist,
   input  logic                       taken,
   output logic signed [Y_BITS-1:0]   y,
   output logic                       mispred,
   output logic                       train,
   output logic [(HIST+1)*W_BITS-1:0] new_row
);

   localparam logic [W_BITS-1:0] W_MAX = {1'b0, {(W_BITS-1){1'b1}}};
   localparam logic [W_BITS-1:0] W_MIN = {1'b1, {(W_BITS-1){1'b0}}};
   localparam logic signed [Y_BITS-1:0] THETA_Y = Y_BITS'(THETA);

   // Bias input is a constant +1, so it rides in bit 0 alongside the history.
   logic [HIST:0] x_vec;
   assign x_vec = {hist, 1'b1};

   logic signed [Y_BITS-1:0] term [HIST+1];

   for (genvar gi = 0; gi <= HIST; gi++) begin : g_w
      logic [W_BITS-1:0]        w;
      logic signed [Y_BITS-1:0] w_ext;
      assign w     = row[row_lsb(gi, W_BITS) +: W_BITS];
      assign w_ext = {{(Y_BITS-W_BITS){w[W_BITS-1]}}, w};
      assign term[gi] = x_vec[gi] ? w_ext : -w_ext;
      // t*x = +1 exactly when the outcome matches the input's sign.
      assign new_row[row_lsb(gi, W_BITS) +: W_BITS] =
         (taken == x_vec[gi]) ? ((w == W_MAX) ? w : w + W_BITS'(1))
                              : ((w == W_MIN) ? w : w - W_BITS'(1));
   end

   always_comb begin
      y = '0;
      for (int i = 0; i <= HIST; i++) begin
         y = y + term[i];
      end
   end

   assign mispred = ~y[Y_BITS-1] ^ taken;
   assign train   = mispred | ((y <= THETA_Y) && (y >= -THETA_Y));

endmodule

// File: rtl/perceptron_update_engine.sv
// Retirement-side perceptron trainer: read row, evaluate, conditionally write back.
// 5 cycles per update at read latency 1; upd_ready only in IDLE. Optional: PERCEPTRON_UPD_STATS_EN.
module perceptron_update_engine
   import perceptron_pkg::*;
#(
   parameter int INDEX_BITS = 7,
   parameter int HIST       = 28,
   parameter int W_BITS     = 8,
   parameter int THETA      = THETA_DEFAULT,
   localparam int Y_BITS    = y_bits(W_BITS, HIST),
   localparam int ROW_BITS  = (HIST+1)*W_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     upd_valid,
   output logic                     upd_ready,
   input  logic [INDEX_BITS-1:0]    upd_idx,
   input  logic [HIST-1:0]          upd_hist,
   input  logic                     upd_taken,
   output logic                     mem_rd_en,
   output logic [INDEX_BITS-1:0]    mem_rd_idx,
   input  logic                     mem_rd_valid,
   input  logic [ROW_BITS-1:0]      mem_rd_data,
   output logic                     mem_wr_en,
   output logic [INDEX_BITS-1:0]    mem_wr_idx,
   output logic [ROW_BITS-1:0]      mem_wr_data,
   output logic                     upd_done,
   output logic                     upd_trained,
   output logic                     upd_mispred,
   output logic [Y_BITS-1:0]        upd_y
`ifdef PERCEPTRON_UPD_STATS_EN
   ,
   output logic [31:0]              stat_updates,
   output logic [31:0]              stat_mispred,
   output logic [31:0]              stat_trained
`endif
);

   upd_state_t state_q, state_d;

   logic [INDEX_BITS-1:0]    idx_q;
   logic [HIST-1:0]          hist_q;
   logic                     taken_q;
   logic [ROW_BITS-1:0]      row_q;

   logic signed [Y_BITS-1:0] dot_y;
   logic                     dot_mispred;
   logic                     dot_train;
   logic [ROW_BITS-1:0]      dot_row;

   logic                     train_q;

   perceptron_dot #(
      .HIST   (HIST),
      .W_BITS (W_BITS),
      .THETA  (THETA),
      .Y_BITS (Y_BITS)
   ) u_dot (
      .row     (row_q),
      .hist    (hist_q),
      .taken   (taken_q),
      .y       (dot_y),
      .mispred (dot_mispred),
      .train   (dot_train),
      .new_row (dot_row)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      upd_ready  = 1'b0;
      mem_rd_en  = 1'b0;
      mem_rd_idx = '0;
      mem_wr_en  = 1'b0;
      upd_done   = 1'b0;
      case (state_q)
         IDLE: begin
            upd_ready = 1'b1;
            if (upd_valid) state_d = RD;
         end
         RD: begin
            mem_rd_en  = 1'b1;
            mem_rd_idx = idx_q;
            state_d    = WAIT;
         end
         WAIT: begin
            if (mem_rd_valid) state_d = EVAL;
         end
         EVAL: begin
            state_d = WB;
         end
         WB: begin
            mem_wr_en = train_q;
            upd_done  = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Write-back payload and status are frozen in EVAL so they hold through WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         hist_q      <= '0;
         taken_q     <= 1'b0;
         row_q       <= '0;
         train_q     <= 1'b0;
         mem_wr_idx  <= '0;
         mem_wr_data <= '0;
         upd_trained <= 1'b0;
         upd_mispred <= 1'b0;
         upd_y       <= '0;
      end else begin
         if (state_q == IDLE && upd_valid) begin
            idx_q   <= upd_idx;
            hist_q  <= upd_hist;
            taken_q <= upd_taken;
         end
         if (state_q == WAIT && mem_rd_valid) begin
            row_q <= mem_rd_data;
         end
         if (state_q == EVAL) begin
            train_q     <= dot_train;
            mem_wr_idx  <= idx_q;
            mem_wr_data <= dot_row;
            upd_trained <= dot_train;
            upd_mispred <= dot_mispred;
            upd_y       <= dot_y;
         end
      end
   end

`ifdef PERCEPTRON_UPD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_updates <= '0;
         stat_mispred <= '0;
         stat_trained <= '0;
      end else if (state_q == WB) begin
         if (stat_updates != 32'hFFFF_FFFF) stat_updates <= stat_updates + 32'd1;
         if (upd_mispred && stat_mispred != 32'hFFFF_FFFF) stat_mispred <= stat_mispred + 32'd1;
         if (upd_trained && stat_trained != 32'hFFFF_FFFF) stat_trained <= stat_trained + 32'd1;
      end
   end
`endif

endmodule
